// File: rtl/bk_pipe_adder.sv
// -----------------------------------------------------------------------------
// bk_pipe_adder
//
// Pipelined add/subtract unit. Carries come from a Brent-Kung parallel-prefix
// tree (up-sweep then down-sweep). The result then passes through PIPE_STAGES
// registers that advance together under a valid/ready handshake.
//
// Parameters
//   ADDER_SIZE  : operand width, one of 4, 8, 16, 32, 64, 128 (default 32)
//   PIPE_STAGES : register stages from input handshake to output, 1..4 (default 2)
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset, clears every stage
//   in_op1       : operand A
//   in_op2       : operand B
//   in_cin       : carry-in (add) / borrow-in (subtract)
//   in_sub       : 0 = add, 1 = subtract
//   in_s_valid   : upstream offers operands
//   out_s_ready  : operands are accepted this cycle (pipeline advances)
//   out_res      : result
//   out_cout     : raw carry-out of the prefix tree (1 = no borrow on subtract)
//   out_m_valid  : out_res / out_cout / out_ovf are valid
//   in_m_ready   : downstream accepts the result
//   out_ovf      : signed overflow flag (only when BK_PIPE_OVF_EN is defined)
//
// Optional feature macro: BK_PIPE_OVF_EN adds the out_ovf port and its logic.
// -----------------------------------------------------------------------------
module bk_pipe_adder #(
    parameter int ADDER_SIZE  = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDER_SIZE-1:0] in_op1,
    input  logic [ADDER_SIZE-1:0] in_op2,
    input  logic                  in_cin,
    input  logic                  in_sub,
    input  logic                  in_s_valid,
    output logic                  out_s_ready,
    output logic [ADDER_SIZE-1:0] out_res,
    output logic                  out_cout,
    output logic                  out_m_valid,
    input  logic                  in_m_ready
`ifdef BK_PIPE_OVF_EN
    ,
    output logic                  out_ovf
`endif
);

    localparam int N     = ADDER_SIZE;
    localparam int LOG_N = $clog2(ADDER_SIZE);
    localparam int LAST  = PIPE_STAGES - 1;
`ifdef BK_PIPE_OVF_EN
    localparam int DW    = ADDER_SIZE + 2;
`else
    localparam int DW    = ADDER_SIZE + 1;
`endif

    // Brent-Kung prefix over (g,p). Bit 0 already carries the carry-in folded
    // into its generate term, so the returned g[i] is the carry out of bit i.
    function automatic logic [N-1:0] bk_carry(input logic [N-1:0] g_in,
                                              input logic [N-1:0] p_in);
        logic [N-1:0] g;
        logic [N-1:0] p;
        g = g_in;
        p = p_in;
        // Up-sweep: node i (i+1 a multiple of 2^l) absorbs the span below it.
        for (int l = 1; l <= LOG_N; l++) begin
            for (int i = 0; i < N; i++) begin
                if (((i + 1) % (1 << l)) == 0) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << (l - 1))]);
                    p[i] = p[i] & p[i - (1 << (l - 1))];
                end
            end
        end
        // Down-sweep: fill in the midpoints from the completed prefixes.
        for (int l = LOG_N - 1; l >= 1; l--) begin
            for (int i = 0; i < N; i++) begin
                if ((i >= (1 << l)) && (((i + 1) % (1 << l)) == (1 << (l - 1)))) begin
                    g[i] = g[i] | (p[i] & g[i - (1 << (l - 1))]);
                    p[i] = p[i] & p[i - (1 << (l - 1))];
                end
            end
        end
        return g;
    endfunction

    logic [N-1:0]    opb_eff;
    logic            cin_eff;
    logic [N-1:0]    gen_w;
    logic [N-1:0]    prop_w;
    logic [N-1:0]    cout_vec;
    logic [N-1:0]    carry_w;
    logic [N-1:0]    sum_w;
    logic [DW-1:0]   data_d;
    logic [DW-1:0]   data_q [PIPE_STAGES];
    logic [LAST:0]   vld_q;
    logic            advance;
    logic            accept;

    // Subtraction is A + ~B + ~borrow; cout = 1 then means "no borrow".
    assign opb_eff = in_sub ? ~in_op2 : in_op2;
    assign cin_eff = in_sub ? ~in_cin : in_cin;

    assign prop_w = in_op1 ^ opb_eff;
    always_comb begin
        gen_w    = in_op1 & opb_eff;
        gen_w[0] = gen_w[0] | (prop_w[0] & cin_eff);
    end

    assign cout_vec = bk_carry(gen_w, prop_w);
    assign carry_w  = {cout_vec[N-2:0], cin_eff};
    assign sum_w    = prop_w ^ carry_w;

`ifdef BK_PIPE_OVF_EN
    assign data_d = {carry_w[N-1] ^ cout_vec[N-1], cout_vec[N-1], sum_w};
`else
    assign data_d = {cout_vec[N-1], sum_w};
`endif

    assign advance     = in_m_ready || !vld_q[LAST];
    assign accept      = in_s_valid && advance;
    assign out_s_ready = advance;

    // Stage boundaries: every stage shifts on advance, bubbles included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                data_q[s] <= '0;
            end
        end else if (advance) begin
            vld_q[0]  <= accept;
            data_q[0] <= data_d;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                vld_q[s]  <= vld_q[s-1];
                data_q[s] <= data_q[s-1];
            end
        end
    end

    assign out_m_valid = vld_q[LAST];
`ifdef BK_PIPE_OVF_EN
    assign {out_ovf, out_cout, out_res} = data_q[LAST];
`else
    assign {out_cout, out_res} = data_q[LAST];
`endif

endmodule

// File: doc/bk_pipe_adder.md
BK_PIPE_ADDER -- requirements
Module: bk_pipe_adder

Interface
REQ-001 Parameter ADDER_SIZE, default 32, operand width in bits; legal values 4, 8, 16, 32, 64, 128.
REQ-002 Parameter PIPE_STAGES, default 2, register stages from input handshake to output; legal range 1..4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 in_op1  input  ADDER_SIZE  operand A.
REQ-006 in_op2  input  ADDER_SIZE  operand B.
REQ-007 in_cin  input  1  carry-in (add) / borrow-in (subtract).
REQ-008 in_sub  input  1  0 = add, 1 = subtract.
REQ-009 in_s_valid  input  1  upstream offers operands.
REQ-010 out_s_ready  output  1  block accepts operands this cycle.
REQ-011 out_res  output  ADDER_SIZE  result.
REQ-012 out_cout  output  1  raw carry-out of the prefix tree.
REQ-013 out_m_valid  output  1  out_res/out_cout/out_ovf valid.
REQ-014 in_m_ready  input  1  downstream accepts result.
REQ-015 out_ovf  output  1  signed overflow flag; present only with BK_PIPE_OVF_EN.

Function
REQ-016 Carry computation SHALL use a Brent-Kung parallel-prefix tree (up-sweep and down-sweep) over ADDER_SIZE bits; ripple-carry is not acceptable.
REQ-017 Add: {out_cout,out_res} = in_op1 + in_op2 + in_cin, computed at ADDER_SIZE+1 bits.
REQ-018 Subtract: operand B is ~in_op2 and the carry-in is ~in_cin, so out_res = in_op1 - in_op2 - in_cin mod 2^ADDER_SIZE; out_cout = 1 means no borrow.
REQ-019 Operands are captured when in_s_valid && out_s_ready (the accept).
REQ-020 advance = in_m_ready || !out_m_valid. All pipeline stages shift together on advance; the pipeline does not collapse bubbles.
REQ-021 out_s_ready = advance, combinationally.
REQ-022 With no stall, out_m_valid SHALL assert exactly PIPE_STAGES cycles after accept. Each stall cycle (out_m_valid && !in_m_ready) adds one cycle.
REQ-023 A valid bit travels with every stage. A stage without valid data SHALL still shift, but its valid bit stays 0.
REQ-024 While stalled, out_res, out_cout, out_ovf and out_m_valid SHALL hold stable; no accepted operand is lost or duplicated.
REQ-025 Back-to-back accepts with in_m_ready held at 1 SHALL give throughput of 1 result per cycle, in order.
REQ-026 Placement of stage boundaries inside the prefix tree is implementation-defined; only latency and throughput are normative.

Reset
REQ-027 rst_n low SHALL clear all stage valid bits asynchronously. out_m_valid = 0, out_res = 0, out_cout = 0, out_ovf = 0.
REQ-028 Assertion of rst_n mid-operation SHALL discard all in-flight results; none are emitted after release.
REQ-029 Reset release is synchronous to clk. The first accept is possible in the first cycle after release, since out_s_ready = 1 because the pipeline is empty.

Configuration
REQ-030 Macro BK_PIPE_OVF_EN defined: port out_ovf exists. It equals the signed overflow of the operation: the carry into the MSB XOR the carry out of the MSB, using the effective operand B. It is pipelined with the result.
REQ-031 Macro BK_PIPE_OVF_EN undefined: port out_ovf and its logic are absent. All other behaviour is identical.

Verification
REQ-032 ADDER_SIZE=16, PIPE_STAGES=3: accept op1=FFFF, op2=0001, cin=0, sub=0 at cycle 0 -> out_m_valid at cycle 3, out_res=0000, out_cout=1.
REQ-033 Subtract op1=0005, op2=0007, cin=0 -> out_res=FFFE, out_cout=0. With BK_PIPE_OVF_EN, out_ovf=0.
REQ-034 With BK_PIPE_OVF_EN: add 7FFF+0001, cin=0 -> out_res=8000, out_ovf=1, out_cout=0.
REQ-035 Stream 8 random accepts back-to-back. Hold in_m_ready=0 for 4 cycles mid-stream -> out_s_ready=0 during the stall, outputs stable, all 8 results in order and matching the ADDER_SIZE+1-bit golden sum.
REQ-036 Assert rst_n=0 for 1 cycle with 3 operations in flight -> out_m_valid=0 immediately, and no stale result appears afterwards.
REQ-037 Repeat REQ-035 for ADDER_SIZE in {4, 32, 128} and PIPE_STAGES in {1, 4} -> zero mismatches, latency per REQ-022.
